unconfig_int_acc_reduce: RTL and testbench
==========================================

Name: unconfig_int_acc_reduce

Overview:
- Downstream consumer of the registered approximate integer adder output, c.
- Accumulates ACC_LEN consecutive adder results into one wide sum and emits it through a valid/ready handshake.
- Applies the same OP_BITWIDTH truncation as the adder: only the top OP_BITWIDTH bits of each sample contribute.
- Used as the reduction stage of approximate dot-product and sum kernels.

Parameters:
- OP_BITWIDTH, 32: significant (kept) upper bits of each input sample; the low DATA_PATH_BITWIDTH-OP_BITWIDTH bits are forced to 0.
- DATA_PATH_BITWIDTH, 32: width of the input sample bus.
- ACC_LEN, 8: samples per reduction; must be 1 or more.
- CNT_BITWIDTH (localparam), clog2(ACC_LEN+1): sample counter width.
- ACC_BITWIDTH (localparam), DATA_PATH_BITWIDTH+CNT_BITWIDTH: accumulator and output width; overflow is impossible.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear; discards any partial sum.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  DATA_PATH_BITWIDTH  two's-complement sample (adder c).
- out_valid  out  1  out_data holds a completed sum.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  ACC_BITWIDTH  signed completed sum.
- out_count  out  CNT_BITWIDTH  samples accepted in the current reduction.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, accumulator=0, out_count=0, out_data=0, out_valid=0. in_ready reads 1 once rst is released.
- Sample masking: masked = in_data with bits [DATA_PATH_BITWIDTH-OP_BITWIDTH-1:0] forced to 0. No masking when OP_BITWIDTH==DATA_PATH_BITWIDTH. The masked sample is sign-extended to ACC_BITWIDTH.
- Accept: a sample is accepted when in_valid && in_ready. Then accumulator += masked and out_count += 1.
- in_ready = (state != DONE). It is a combinational decode of registered state only.
- IDLE (out_count=0): an accept moves to ACC. If ACC_LEN==1, an accept moves directly to DONE.
- ACC: an accept that brings out_count to ACC_LEN moves to DONE. That same edge registers out_data = accumulator + masked and sets out_valid=1.
- DONE:
  - out_valid=1; out_data is held stable.
  - When out_ready=1, the next edge clears the accumulator, out_count and out_valid and moves to IDLE.
  - No sample is accepted in a DONE cycle, including the handshake cycle itself (one-bubble turnaround).
- Latency: out_valid rises one cycle after the final accept. Back-to-back reductions cost ACC_LEN + 1 cycles each, given continuous valid and ready.
- clr:
  - In IDLE or ACC: the next edge zeroes the accumulator and out_count and moves to IDLE. A sample presented that cycle is dropped, even if handshaken.
  - In DONE: clr is ignored; a completed result is never lost.
  - clr takes priority over accept.
- out_data keeps its value after the DONE handshake until the next completion. Consumers rely only on out_valid.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge. The partial sum is lost.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, ACC=2'd1, DONE=2'd2;
  - a clog2 constant function reused by the apx operator family.
- Optional sub-module apx_trunc_mask (combinational, parameterised by OP_BITWIDTH/DATA_PATH_BITWIDTH). The adder-side truncation logic reuses it.
- Counter, accumulator and FSM stay in this module.

Test Plan:
- Defaults; 8 consecutive samples of 5, out_ready=1 -> out_valid one cycle after the 8th accept; out_data=40; out_count=8; IDLE one cycle later.
- OP_BITWIDTH=16, ACC_LEN=2; samples 0x0001_FFFF twice -> out_data=0x0_0002_0000.
- Eight samples of 0xFFFF_FFFD (-3) -> out_data=-24, i.e. 36-bit 0xF_FFFF_FFE8.
- Completion with out_ready=0 for 5 cycles, in_valid held high -> out_valid=1, out_data stable, in_ready=0 throughout; ready pulse -> IDLE next edge, next accept the cycle after.
- Four samples of 7, then clr with in_valid=1, then 8 samples of 1 -> single result out_data=8; clr asserted during DONE leaves out_valid/out_data unchanged.
- rst pulsed low between clock edges after 3 samples -> out_valid, out_data, out_count go to 0 immediately; a following run of 8 samples of 2 -> 16.

Source files
------------

// File: rtl/unconfig_int_acc_reduce_pkg.sv
// Shared definitions for the approximate integer operator family:
// reduction FSM state encoding and a constant clog2 helper.
package unconfig_int_acc_reduce_pkg;

  // Reduction FSM states; 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

  // Ceiling log2, usable in parameter/localparam expressions.
  // clog2(1)=0, clog2(2)=1, clog2(3)=2, clog2(9)=4.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/unconfig_int_acc_reduce_trunc_mask.sv
// Combinational operand truncation: keeps the top OP_BITWIDTH bits of a
// DATA_PATH_BITWIDTH sample and forces the remaining low bits to zero.
// Shared with the adder-side truncation so both stages drop the same bits.
module apx_trunc_mask #(
  parameter int OP_BITWIDTH        = 32,
  parameter int DATA_PATH_BITWIDTH = 32
) (
  input  logic [DATA_PATH_BITWIDTH-1:0] in_data,
  output logic [DATA_PATH_BITWIDTH-1:0] masked
);

  // Number of low bits that are discarded (0 means pass-through).
  localparam int LOW_BITS = DATA_PATH_BITWIDTH - OP_BITWIDTH;

  // Per-bit keep/zero decision resolved at elaboration time.
  for (genvar gi = 0; gi < DATA_PATH_BITWIDTH; gi++) begin : g_bit
    if (gi >= LOW_BITS) begin : g_keep
      assign masked[gi] = in_data[gi];
    end else begin : g_zero
      assign masked[gi] = 1'b0;
    end
  end

endmodule

// File: rtl/unconfig_int_acc_reduce.sv
// Reduction stage behind the approximate adder: sums ACC_LEN truncated
// samples into a wide signed accumulator and hands the total downstream
// through a valid/ready handshake with a one-bubble turnaround.
module unconfig_int_acc_reduce
  import unconfig_int_acc_reduce_pkg::*;
#(
  parameter  int OP_BITWIDTH        = 32,
  parameter  int DATA_PATH_BITWIDTH = 32,
  parameter  int ACC_LEN            = 8,
  localparam int CNT_BITWIDTH       = clog2(ACC_LEN + 1),
  localparam int ACC_BITWIDTH       = DATA_PATH_BITWIDTH + CNT_BITWIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_BITWIDTH-1:0]       out_data,
  output logic [CNT_BITWIDTH-1:0]       out_count
);

  localparam logic [CNT_BITWIDTH-1:0] LAST_COUNT = CNT_BITWIDTH'(ACC_LEN);

  acc_state_t                    state;
  acc_state_t                    state_next;
  logic [ACC_BITWIDTH-1:0]       acc;
  logic [ACC_BITWIDTH-1:0]       acc_next;
  logic [CNT_BITWIDTH-1:0]       count;
  logic [CNT_BITWIDTH-1:0]       count_next;
  logic [ACC_BITWIDTH-1:0]       result;
  logic [ACC_BITWIDTH-1:0]       result_next;
  logic                          valid;
  logic                          valid_next;

  logic [DATA_PATH_BITWIDTH-1:0] masked;
  logic [ACC_BITWIDTH-1:0]       masked_ext;
  logic [ACC_BITWIDTH-1:0]       acc_sum;
  logic [CNT_BITWIDTH-1:0]       count_inc;
  logic                          accept;
  logic                          last_accept;

  apx_trunc_mask #(
    .OP_BITWIDTH        (OP_BITWIDTH),
    .DATA_PATH_BITWIDTH (DATA_PATH_BITWIDTH)
  ) u_trunc_mask (
    .in_data (in_data),
    .masked  (masked)
  );

  // Sign-extend the truncated sample; the extra CNT_BITWIDTH bits make
  // overflow impossible for ACC_LEN samples.
  assign masked_ext = {{CNT_BITWIDTH{masked[DATA_PATH_BITWIDTH-1]}}, masked};
  assign acc_sum    = acc + masked_ext;
  assign count_inc  = count + CNT_BITWIDTH'(1);

  // Ready depends only on registered state, so no combinational path
  // from any input reaches it.
  assign in_ready    = (state != DONE);
  assign accept      = in_valid && in_ready;
  assign last_accept = (count_inc == LAST_COUNT);

  assign out_valid = valid;
  assign out_data  = result;
  assign out_count = count;

  // Next-state and datapath update; clr wins over accept, and is ignored
  // while a completed result waits for the consumer.
  always_comb begin
    state_next  = state;
    acc_next    = acc;
    count_next  = count;
    result_next = result;
    valid_next  = valid;
    case (state)
      IDLE, ACC: begin
        if (clr) begin
          state_next = IDLE;
          acc_next   = '0;
          count_next = '0;
        end else if (accept) begin
          acc_next   = acc_sum;
          count_next = count_inc;
          if (last_accept) begin
            state_next  = DONE;
            result_next = acc_sum;
            valid_next  = 1'b1;
          end else begin
            state_next = ACC;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
          acc_next   = '0;
          count_next = '0;
          valid_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        acc_next   = '0;
        count_next = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      acc    <= '0;
      count  <= '0;
      result <= '0;
      valid  <= 1'b0;
    end else begin
      state  <= state_next;
      acc    <= acc_next;
      count  <= count_next;
      result <= result_next;
      valid  <= valid_next;
    end
  end

endmodule

// File: tb/tb_unconfig_int_acc_reduce.sv
// Self-checking bench: two instances (defaults, and OP_BITWIDTH=16 with
// ACC_LEN=2) driven by directed vectors, checked every cycle against a
// transaction-level model and at key points against literal values.
module tb_unconfig_int_acc_reduce;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Instance A: defaults (32/32/8 -> 36-bit sum, 4-bit count)
  logic        a_clr, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data;
  logic [35:0] a_out_data;
  logic [3:0]  a_out_count;

  // Instance B: OP_BITWIDTH=16, ACC_LEN=2 -> 34-bit sum, 2-bit count
  logic        b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data;
  logic [33:0] b_out_data;
  logic [1:0]  b_out_count;

  unconfig_int_acc_reduce dut_a (
    .clk       (clk),
    .rst       (rst),
    .clr       (a_clr),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_count (a_out_count)
  );

  unconfig_int_acc_reduce #(
    .OP_BITWIDTH        (16),
    .DATA_PATH_BITWIDTH (32),
    .ACC_LEN            (2)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .clr       (b_clr),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_count (b_out_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Signed value of a sample after dropping its low (32-op) bits.
  function automatic longint mask_s(input logic [31:0] d, input int op);
    longint v;
    v = longint'($signed(d));
    return (v >>> (32 - op)) << (32 - op);
  endfunction

  // Transaction-level model: running sum of accepted samples, number
  // accepted, and a "result pending" flag that blocks input until taken.
  longint ma_sum = 0, ma_result = 0;
  int     ma_cnt = 0;
  bit     ma_pending = 1'b0;
  longint mb_sum = 0, mb_result = 0;
  int     mb_cnt = 0;
  bit     mb_pending = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma_sum <= 0; ma_result <= 0; ma_cnt <= 0; ma_pending <= 1'b0;
    end else if (ma_pending) begin
      if (a_out_ready) begin
        ma_pending <= 1'b0; ma_sum <= 0; ma_cnt <= 0;
      end
    end else if (a_clr) begin
      ma_sum <= 0; ma_cnt <= 0;
    end else if (a_in_valid) begin
      ma_sum <= ma_sum + mask_s(a_in_data, 32);
      ma_cnt <= ma_cnt + 1;
      if (ma_cnt + 1 == 8) begin
        ma_pending <= 1'b1;
        ma_result  <= ma_sum + mask_s(a_in_data, 32);
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mb_sum <= 0; mb_result <= 0; mb_cnt <= 0; mb_pending <= 1'b0;
    end else if (mb_pending) begin
      if (b_out_ready) begin
        mb_pending <= 1'b0; mb_sum <= 0; mb_cnt <= 0;
      end
    end else if (b_clr) begin
      mb_sum <= 0; mb_cnt <= 0;
    end else if (b_in_valid) begin
      mb_sum <= mb_sum + mask_s(b_in_data, 16);
      mb_cnt <= mb_cnt + 1;
      if (mb_cnt + 1 == 2) begin
        mb_pending <= 1'b1;
        mb_result  <= mb_sum + mask_s(b_in_data, 16);
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      logic [35:0] ea;
      logic [33:0] eb;
      ea = ma_result[35:0];
      eb = mb_result[33:0];
      check("a_out_valid", 64'(a_out_valid), 64'(ma_pending));
      check("a_in_ready",  64'(a_in_ready),  64'(!ma_pending));
      check("a_out_count", 64'(a_out_count), 64'(ma_cnt));
      check("a_out_data",  64'(a_out_data),  64'(ea));
      check("b_out_valid", 64'(b_out_valid), 64'(mb_pending));
      check("b_in_ready",  64'(b_in_ready),  64'(!mb_pending));
      check("b_out_count", 64'(b_out_count), 64'(mb_cnt));
      check("b_out_data",  64'(b_out_data),  64'(eb));
      if (a_out_valid && a_out_ready)
        $display("A txn out_data=%h out_count=%0d t=%0t", a_out_data, a_out_count, $time);
      if (b_out_valid && b_out_ready)
        $display("B txn out_data=%h out_count=%0d t=%0t", b_out_data, b_out_count, $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    a_clr = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_clr = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_out_data",  64'(a_out_data),  64'd0);
    check("rst_a_out_count", 64'(a_out_count), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_a_in_ready", 64'(a_in_ready), 64'd1);

    // 8 x 5 with consumer ready: result visible right after the 8th accept
    a_out_ready = 1; a_in_valid = 1; a_in_data = 32'd5;
    repeat (7) @(negedge clk);
    check("t1_not_yet_valid", 64'(a_out_valid), 64'd0);
    check("t1_count7", 64'(a_out_count), 64'd7);
    @(negedge clk);
    check("t1_valid", 64'(a_out_valid), 64'd1);
    check("t1_data40", 64'(a_out_data), 64'd40);
    check("t1_model40", 64'(ma_result), 64'd40);
    check("t1_count8", 64'(a_out_count), 64'd8);
    check("t1_in_ready0", 64'(a_in_ready), 64'd0);
    a_in_valid = 0;
    @(negedge clk);
    check("t1_idle_valid", 64'(a_out_valid), 64'd0);
    check("t1_idle_count", 64'(a_out_count), 64'd0);
    check("t1_idle_hold40", 64'(a_out_data), 64'd40);

    // 8 x -3
    a_in_valid = 1; a_in_data = 32'hFFFF_FFFD;
    repeat (8) @(negedge clk);
    check("t3_data_neg24", 64'(a_out_data), 64'(36'hF_FFFF_FFE8));
    check("t3_model_neg24", 64'(ma_result), 64'(-64'sd24));
    a_in_valid = 0;
    @(negedge clk);

    // Backpressure: completion held for 5 cycles with in_valid high
    a_out_ready = 0; a_in_valid = 1; a_in_data = 32'd1;
    repeat (8) @(negedge clk);
    check("t4_valid", 64'(a_out_valid), 64'd1);
    check("t4_data8", 64'(a_out_data), 64'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 64'(a_out_valid), 64'd1);
      check("t4_hold_data", 64'(a_out_data), 64'd8);
      check("t4_hold_in_ready", 64'(a_in_ready), 64'd0);
      check("t4_hold_count", 64'(a_out_count), 64'd8);
    end
    a_out_ready = 1;
    @(negedge clk);
    check("t4_idle_valid", 64'(a_out_valid), 64'd0);
    check("t4_idle_count", 64'(a_out_count), 64'd0);
    a_out_ready = 0;
    @(negedge clk);
    check("t4_next_accept", 64'(a_out_count), 64'd1);
    a_in_valid = 0; a_clr = 1;
    @(negedge clk);
    a_clr = 0;
    check("t4_clr_count", 64'(a_out_count), 64'd0);

    // 4 x 7, clr with a live sample, then 8 x 1 -> 8
    a_in_valid = 1; a_in_data = 32'd7;
    repeat (4) @(negedge clk);
    check("t5_count4", 64'(a_out_count), 64'd4);
    a_clr = 1;
    @(negedge clk);
    check("t5_clr_count0", 64'(a_out_count), 64'd0);
    a_clr = 0; a_in_data = 32'd1;
    repeat (8) @(negedge clk);
    check("t5_valid", 64'(a_out_valid), 64'd1);
    check("t5_data8", 64'(a_out_data), 64'd8);
    check("t5_model8", 64'(ma_result), 64'd8);
    a_in_valid = 0; a_clr = 1;
    repeat (2) @(negedge clk);
    check("t5_done_clr_valid", 64'(a_out_valid), 64'd1);
    check("t5_done_clr_data", 64'(a_out_data), 64'd8);
    check("t5_done_clr_count", 64'(a_out_count), 64'd8);
    a_clr = 0; a_out_ready = 1;
    @(negedge clk);
    check("t5_handshake", 64'(a_out_valid), 64'd0);

    // Asynchronous reset between edges after 3 samples
    a_in_valid = 1; a_in_data = 32'd9;
    repeat (3) @(negedge clk);
    check("t6_count3", 64'(a_out_count), 64'd3);
    a_in_valid = 0;
    #2 rst = 1'b0;
    #1;
    check("t6_async_valid", 64'(a_out_valid), 64'd0);
    check("t6_async_data", 64'(a_out_data), 64'd0);
    check("t6_async_count", 64'(a_out_count), 64'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    a_in_valid = 1; a_in_data = 32'd2;
    repeat (8) @(negedge clk);
    check("t6_valid", 64'(a_out_valid), 64'd1);
    check("t6_data16", 64'(a_out_data), 64'd16);
    a_in_valid = 0;
    @(negedge clk);

    // Instance B: 16 kept bits, two samples per reduction
    b_out_ready = 1; b_in_valid = 1; b_in_data = 32'h0001_FFFF;
    repeat (2) @(negedge clk);
    check("t2_valid", 64'(b_out_valid), 64'd1);
    check("t2_data", 64'(b_out_data), 64'(34'h0_0002_0000));
    check("t2_model", 64'(mb_result), 64'h2_0000);
    check("t2_count", 64'(b_out_count), 64'd2);
    b_in_valid = 0;
    @(negedge clk);
    b_in_valid = 1; b_in_data = 32'hFFFF_8001;
    repeat (2) @(negedge clk);
    check("t2_neg_data", 64'(b_out_data), 64'(34'h3_FFFE_0000));
    // Continuous valid/ready: one result every ACC_LEN+1 = 3 cycles
    b_in_data = 32'h0003_0000;
    repeat (6) @(negedge clk);
    check("t2_b2b_data", 64'(b_out_data), 64'(34'h0_0006_0000));
    check("t2_b2b_valid", 64'(b_out_valid), 64'd1);
    b_in_valid = 0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
